// File: rtl/regfile_bypass_clr_pkg.sv
// regfile_pkg: shared definitions for the bypassing, self-clearing register file.
//   - ST_IDLE / ST_CLEAR encoding of the clear engine
//   - default geometry constants
//   - depth_of(): entry count for a given index width
package regfile_pkg;

   localparam int DEF_DATA_W   = 64;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_ZERO_IDX = 31;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Entry count is a plain power of two, so no clog2 is needed anywhere.
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/regfile_bypass_clr_if.sv
// regfile_bypass_clr_if: decode/writeback side of the register file.
//   RA, RB     read indices          (master -> slave)
//   RW, BusW   write index / data    (master -> slave)
//   RegWr      write enable          (master -> slave)
//   Clear      request full sweep    (master -> slave)
//   BusA, BusB combinational reads   (slave -> master)
//   Busy       clear sweep running   (slave -> master)
interface regfile_bypass_clr_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);

   logic [ADDR_W-1:0] RA;
   logic [ADDR_W-1:0] RB;
   logic [ADDR_W-1:0] RW;
   logic [DATA_W-1:0] BusW;
   logic              RegWr;
   logic              Clear;
   logic [DATA_W-1:0] BusA;
   logic [DATA_W-1:0] BusB;
   logic              Busy;

   modport master (
      output RA, RB, RW, BusW, RegWr, Clear,
      input  BusA, BusB, Busy
   );

   modport slave (
      input  RA, RB, RW, BusW, RegWr, Clear,
      output BusA, BusB, Busy
   );

endinterface

// File: rtl/regfile_bypass_clr_read_port.sv
// regfile_read_port: one combinational read port with read priority
//   busy -> 0, hardwired-zero index -> 0, same-cycle write -> BusW, else stored word.
// Ports:
//   idx_i    read index
//   word_i   stored array word at idx_i
//   rw_i     write index this cycle
//   regwr_i  write enable this cycle
//   clear_i  clear request this cycle (suppresses forwarding, the write is dropped)
//   busw_i   write data this cycle
//   busy_i   clear sweep in progress
//   data_o   read data
module regfile_read_port #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int HAS_ZERO = 1,
   parameter int ZERO_IDX = 31,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0] idx_i,
   input  logic [DATA_W-1:0] word_i,
   input  logic [ADDR_W-1:0] rw_i,
   input  logic              regwr_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] busw_i,
   input  logic              busy_i,
   output logic [DATA_W-1:0] data_o
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

   logic zero_hit_w;
   logic fwd_hit_w;

   assign zero_hit_w = (HAS_ZERO != 0) && (idx_i == ZERO_ADDR);
   // Forward only a write that will actually land; a Clear in the same cycle drops it.
   assign fwd_hit_w  = (BYPASS != 0) && regwr_i && !clear_i && (rw_i == idx_i);

   always_comb begin
      if (busy_i) begin
         data_o = '0;
      end else if (zero_hit_w) begin
         data_o = '0;
      end else if (fwd_hit_w) begin
         data_o = busw_i;
      end else begin
         data_o = word_i;
      end
   end

endmodule

// File: rtl/regfile_bypass_clr.sv
// regfile_bypass_clr: 2-read / 1-write register file with optional hardwired-zero
// entry, optional write-to-read bypass and a sequential clear engine that zeroes
// one entry per cycle after reset or on a Clear request.
// Ports:
//   Clk    clock, all state on rising edge
//   Reset  asynchronous active-high reset; starts a clear sweep
//   bus    regfile_bypass_clr_if.slave (RA/RB/RW/BusW/RegWr/Clear in, BusA/BusB/Busy out)
module regfile_bypass_clr
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int HAS_ZERO = 1,
   parameter int ZERO_IDX = DEF_ZERO_IDX,
   parameter int BYPASS   = 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   regfile_bypass_clr_if.slave   bus
);

   localparam int                DEPTH     = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic busy_w;
   logic wr_en_w;
   logic zero_wr_w;

   assign zero_wr_w = (HAS_ZERO != 0) && (bus.RW == ZERO_ADDR);

   // ---------------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // ---------------------------------------------------------------- next state
   // NOTE: every output of a combinational process is given a default first so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            // The edge that accepts Clear clears nothing; the sweep starts next edge.
            if (bus.Clear) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         ST_CLEAR: begin
            // Clear requests are ignored here; the sweep never restarts.
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_PTR) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy_w  = (state_q == ST_CLEAR);
      wr_en_w = !busy_w && bus.RegWr && !bus.Clear && !zero_wr_w;
   end

   assign bus.Busy = busy_w;

   // ---------------------------------------------------------------- array
   // NOTE: the storage array has no reset; the clear sweep zeroes it entry by entry,
   // and reads are forced to zero until the sweep completes.
   always_ff @(posedge Clk) begin
      if (busy_w) begin
         mem_q[clr_ptr_q] <= '0;
      end else if (wr_en_w) begin
         mem_q[bus.RW] <= bus.BusW;
      end
   end

   // ---------------------------------------------------------------- read ports
   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .HAS_ZERO (HAS_ZERO),
      .ZERO_IDX (ZERO_IDX),
      .BYPASS   (BYPASS)
   ) u_port_a (
      .idx_i   (bus.RA),
      .word_i  (mem_q[bus.RA]),
      .rw_i    (bus.RW),
      .regwr_i (bus.RegWr),
      .clear_i (bus.Clear),
      .busw_i  (bus.BusW),
      .busy_i  (busy_w),
      .data_o  (bus.BusA)
   );

   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .HAS_ZERO (HAS_ZERO),
      .ZERO_IDX (ZERO_IDX),
      .BYPASS   (BYPASS)
   ) u_port_b (
      .idx_i   (bus.RB),
      .word_i  (mem_q[bus.RB]),
      .rw_i    (bus.RW),
      .regwr_i (bus.RegWr),
      .clear_i (bus.Clear),
      .busw_i  (bus.BusW),
      .busy_i  (busy_w),
      .data_o  (bus.BusB)
   );

endmodule

// File: tb/tb_regfile_bypass_clr.sv
// tb_regfile_bypass_clr: drives identical stimulus into two instances,
//   cfg0: HAS_ZERO=1, BYPASS=1     cfg1: HAS_ZERO=0, BYPASS=0
// and compares both read ports and Busy against a behavioural model.
module tb_regfile_bypass_clr;

   localparam int DW    = 64;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int ZI    = 31;

   logic Clk = 1'b0;
   logic Reset;

   regfile_bypass_clr_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
   regfile_bypass_clr_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

   regfile_bypass_clr #(
      .DATA_W(DW), .ADDR_W(AW), .HAS_ZERO(1), .ZERO_IDX(ZI), .BYPASS(1)
   ) dut0 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (if0)
   );

   regfile_bypass_clr #(
      .DATA_W(DW), .ADDR_W(AW), .HAS_ZERO(0), .ZERO_IDX(ZI), .BYPASS(0)
   ) dut1 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (if1)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;

   // Currently applied inputs (shared by both instances).
   logic [AW-1:0] ra_v, rb_v, rw_v;
   logic [DW-1:0] busw_v;
   logic          regwr_v, clear_v;

   // Reference model: stored contents per configuration plus remaining busy edges.
   logic [DW-1:0] mem_m [2][DEPTH];
   int            sweep_left;

   function automatic bit cfg_has_zero(input int c);
      return (c == 0);
   endfunction

   function automatic bit cfg_bypass(input int c);
      return (c == 0);
   endfunction

   function automatic logic [DW-1:0] exp_read(input int c, input logic [AW-1:0] idx);
      if (sweep_left > 0) return '0;
      if (cfg_has_zero(c) && idx == AW'(ZI)) return '0;
      if (cfg_bypass(c) && regwr_v && !clear_v && rw_v == idx) return busw_v;
      return mem_m[c][idx];
   endfunction

   function automatic logic [DW-1:0] bus_a(input int c);
      return (c == 0) ? if0.BusA : if1.BusA;
   endfunction

   function automatic logic [DW-1:0] bus_b(input int c);
      return (c == 0) ? if0.BusB : if1.BusB;
   endfunction

   function automatic logic busy_of(input int c);
      return (c == 0) ? if0.Busy : if1.Busy;
   endfunction

   // One rising edge of the reference model, using the inputs held across the edge.
   task automatic model_edge();
      if (Reset) return;
      if (sweep_left > 0) begin
         sweep_left--;
         if (sweep_left == 0) begin
            for (int c = 0; c < 2; c++)
               for (int i = 0; i < DEPTH; i++) mem_m[c][i] = '0;
         end
      end else if (clear_v) begin
         sweep_left = DEPTH;
      end else if (regwr_v) begin
         for (int c = 0; c < 2; c++)
            if (!(cfg_has_zero(c) && rw_v == AW'(ZI))) mem_m[c][rw_v] = busw_v;
      end
   endtask

   task automatic set_in(input int ra, input int rb, input int rw,
                         input logic [DW-1:0] busw, input bit regwr, input bit clear);
      ra_v = AW'(ra); rb_v = AW'(rb); rw_v = AW'(rw);
      busw_v = busw; regwr_v = regwr; clear_v = clear;
      if0.RA = ra_v; if0.RB = rb_v; if0.RW = rw_v;
      if0.BusW = busw_v; if0.RegWr = regwr_v; if0.Clear = clear_v;
      if1.RA = ra_v; if1.RB = rb_v; if1.RW = rw_v;
      if1.BusW = busw_v; if1.RegWr = regwr_v; if1.Clear = clear_v;
      #1;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic set_reset(input logic v);
      Reset = v;
      if (v) sweep_left = DEPTH;
      #1;
   endtask

   // Advances until Busy drops (bounded); edges = number of rising edges spent.
   task automatic wait_idle(output int edges);
      edges = 0;
      while (if0.Busy === 1'b1 && edges < 200) begin
         tick();
         edges++;
      end
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      int e;
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (busy_of(c) !== 1'b1 || bus_a(c) !== '0 || bus_b(c) !== '0) begin
            n_err++;
            $display("FAIL reset_state cfg%0d busy=%b A=%h B=%h want busy=1 A=B=0",
                     c, busy_of(c), bus_a(c), bus_b(c));
         end
      end
      set_reset(1'b0);
      wait_idle(e);
      n_cmp++;
      if (e !== DEPTH || if1.Busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_sweep_len got %0d edges (busy1=%b) want %0d", e, if1.Busy, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         set_in(i, DEPTH - 1 - i, 0, '0, 1'b0, 1'b0);
         for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (bus_a(c) !== 64'h0 || bus_b(c) !== 64'h0) begin
               n_err++;
               $display("FAIL reset_zero cfg%0d idx %0d A=%h B=%h want 0", c, i, bus_a(c), bus_b(c));
            end
         end
      end
   endtask

   task automatic test_bypass();
      set_in(5, 5, 5, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (bus_a(c) !== exp_read(c, 5) || bus_b(c) !== exp_read(c, 5)) begin
            n_err++;
            $display("FAIL bypass_same cfg%0d A=%h B=%h want %h", c, bus_a(c), bus_b(c), exp_read(c, 5));
         end
      end
      tick();
      set_in(5, 5, 0, '0, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (bus_a(c) !== 64'hDEAD_BEEF_0123_4567 || bus_b(c) !== 64'hDEAD_BEEF_0123_4567) begin
            n_err++;
            $display("FAIL bypass_after cfg%0d A=%h B=%h want deadbeef01234567", c, bus_a(c), bus_b(c));
         end
      end
   endtask

   task automatic test_zero_reg();
      set_in(31, 31, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (bus_a(c) !== exp_read(c, 31) || bus_b(c) !== exp_read(c, 31)) begin
            n_err++;
            $display("FAIL zero_same cfg%0d A=%h B=%h want %h", c, bus_a(c), bus_b(c), exp_read(c, 31));
         end
      end
      tick();
      set_in(31, 31, 0, '0, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (bus_a(c) !== exp_read(c, 31) || bus_b(c) !== exp_read(c, 31)) begin
            n_err++;
            $display("FAIL zero_after cfg%0d A=%h B=%h want %h", c, bus_a(c), bus_b(c), exp_read(c, 31));
         end
      end
   endtask

   task automatic test_clear_with_write();
      int e;
      for (int i = 1; i <= 30; i++) begin
         set_in(0, 0, i, DW'(i), 1'b1, 1'b0);
         tick();
      end
      for (int i = 1; i <= 30; i++) begin
         set_in(i, 31 - i, 0, '0, 1'b0, 1'b0);
         for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (bus_a(c) !== exp_read(c, AW'(i)) || bus_b(c) !== exp_read(c, AW'(31 - i))) begin
               n_err++;
               $display("FAIL fill cfg%0d idx %0d A=%h B=%h want %h/%h", c, i, bus_a(c), bus_b(c),
                        exp_read(c, AW'(i)), exp_read(c, AW'(31 - i)));
            end
         end
      end
      // Clear beats a simultaneous write, and the write is not forwarded either.
      set_in(7, 7, 7, 64'h77, 1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (bus_a(c) !== 64'h7 || bus_b(c) !== 64'h7) begin
            n_err++;
            $display("FAIL clear_nofwd cfg%0d A=%h B=%h want 7", c, bus_a(c), bus_b(c));
         end
      end
      tick();
      set_in(7, 7, 0, '0, 1'b0, 1'b0);
      wait_idle(e);
      n_cmp++;
      if (e !== DEPTH) begin
         n_err++;
         $display("FAIL clear_sweep_len got %0d edges want %0d", e, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         set_in(i, i, 0, '0, 1'b0, 1'b0);
         for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (bus_a(c) !== 64'h0 || bus_b(c) !== 64'h0) begin
               n_err++;
               $display("FAIL cleared cfg%0d idx %0d A=%h B=%h want 0", c, i, bus_a(c), bus_b(c));
            end
         end
      end
   endtask

   task automatic test_busy_writes();
      int e = 0;
      set_in(0, 0, 3, 64'h3333, 1'b1, 1'b0);
      tick();
      set_in(3, 3, 0, '0, 1'b0, 1'b1);
      tick();
      while (if0.Busy === 1'b1 && e < 200) begin
         if (e == 3 || e == 25)     set_in(3, 3, 3, 64'hABCD, 1'b1, 1'b0);
         else if (e == 10 || e == 20) set_in(3, 3, 0, '0, 1'b0, 1'b1);
         else                       set_in(3, 3, 0, '0, 1'b0, 1'b0);
         for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (bus_a(c) !== exp_read(c, 3) || bus_b(c) !== exp_read(c, 3) || busy_of(c) !== (sweep_left > 0)) begin
               n_err++;
               $display("FAIL busy_read cfg%0d edge %0d A=%h B=%h busy=%b want %h", c, e,
                        bus_a(c), bus_b(c), busy_of(c), exp_read(c, 3));
            end
         end
         tick();
         e++;
      end
      n_cmp++;
      if (e !== DEPTH) begin
         n_err++;
         $display("FAIL busy_sweep_len got %0d edges want %0d", e, DEPTH);
      end
      set_in(3, 3, 0, '0, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (bus_a(c) !== 64'h0 || bus_b(c) !== 64'h0) begin
            n_err++;
            $display("FAIL busy_dropped cfg%0d A=%h B=%h want 0", c, bus_a(c), bus_b(c));
         end
      end
   endtask

   task automatic test_reset_async();
      int e;
      // Mid-sweep: pointer at 17.
      set_in(0, 0, 0, '0, 1'b0, 1'b1);
      tick();
      set_in(0, 0, 0, '0, 1'b0, 1'b0);
      repeat (17) tick();
      set_reset(1'b1);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (busy_of(c) !== 1'b1 || bus_a(c) !== '0 || bus_b(c) !== '0) begin
            n_err++;
            $display("FAIL rst_mid_sweep cfg%0d busy=%b A=%h B=%h want 1/0/0", c, busy_of(c), bus_a(c), bus_b(c));
         end
      end
      tick();
      set_reset(1'b0);
      wait_idle(e);
      n_cmp++;
      if (e !== DEPTH) begin
         n_err++;
         $display("FAIL rst_mid_sweep_len got %0d edges want %0d", e, DEPTH);
      end
      // Mid-idle: a stored value must vanish from the read ports the moment Reset rises.
      set_in(0, 0, 9, 64'h9999_0000_1111_2222, 1'b1, 1'b0);
      tick();
      set_in(9, 9, 0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (if1.BusA !== 64'h9999_0000_1111_2222) begin
         n_err++;
         $display("FAIL idle_store got %h want 9999000011112222", if1.BusA);
      end
      set_reset(1'b1);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (busy_of(c) !== 1'b1 || bus_a(c) !== '0 || bus_b(c) !== '0) begin
            n_err++;
            $display("FAIL rst_mid_idle cfg%0d busy=%b A=%h B=%h want 1/0/0", c, busy_of(c), bus_a(c), bus_b(c));
         end
      end
      tick();
      set_reset(1'b0);
      wait_idle(e);
      n_cmp++;
      if (e !== DEPTH) begin
         n_err++;
         $display("FAIL rst_mid_idle_len got %0d edges want %0d", e, DEPTH);
      end
   endtask

   task automatic test_random();
      int e;
      for (int n = 0; n < 400; n++) begin
         int ra, rb, rw;
         bit we, clr;
         ra  = $urandom_range(0, DEPTH - 1);
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, DEPTH - 1);
         rw  = ($urandom_range(0, 2) == 0) ? ra : $urandom_range(0, DEPTH - 1);
         we  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 60) == 0);
         set_in(ra, rb, rw, {$urandom(), $urandom()}, we, clr);
         for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (bus_a(c) !== exp_read(c, ra_v) || bus_b(c) !== exp_read(c, rb_v) ||
                busy_of(c) !== (sweep_left > 0)) begin
               n_err++;
               $display("FAIL random cfg%0d step %0d A=%h/%h B=%h/%h busy=%b want busy=%0d",
                        c, n, bus_a(c), exp_read(c, ra_v), bus_b(c), exp_read(c, rb_v),
                        busy_of(c), (sweep_left > 0));
            end
         end
         tick();
      end
      set_in(0, 0, 0, '0, 1'b0, 1'b0);
      wait_idle(e);
      n_cmp++;
      if (if0.Busy !== 1'b0) begin
         n_err++;
         $display("FAIL random_settle busy still high after %0d edges", e);
      end
   endtask

   initial begin
      Reset      = 1'b1;
      sweep_left = DEPTH;
      set_in(0, 0, 0, '0, 1'b0, 1'b0);
      repeat (2) tick();
      set_in(3, 4, 0, '0, 1'b0, 1'b0);
      test_reset();
      test_bypass();
      test_zero_reg();
      test_clear_with_write();
      test_busy_writes();
      test_reset_async();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
